// File: rtl/defs.sv
// Shared types and defaults for the ALU scheduler: opcodes, FSM states and the
// operand bundle carried from a requester to the ALU.
package defs;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned ALU_LAT_DEF = 1;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned OP_W        = 2;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    AND = 2'd2,
    NOT = 2'd3
  } op_code_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    op_code_e          op;
  } alu_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: the lowest requester at or above ptr wins,
// otherwise wrap around to the lowest requester overall.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [N-1:0] hi;
  logic [N-1:0] pick;

  always_comb begin
    hi    = req & ({N{1'b1}} << ptr);
    pick  = (|hi) ? hi : req;
    // isolate the lowest set bit of the chosen window
    grant = pick & (~pick + N'(1));
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one external ALU among NUM_REQ requesters, one operation in flight,
// round-robin arbitration and a held response until the consumer accepts.
module alu_sched
  import defs::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ALU_LAT = ALU_LAT_DEF,
  localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output op_code_e                  alu_op_code,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result
);

  localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  sched_state_e       state_q, state_d;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    id_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gidx;
  logic [ID_W-1:0]    ptr_next;
  alu_req_t           sel;
  logic               any_req;
  logic               accept;
  logic               cnt_last;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign any_req  = |req_valid;
  assign accept   = (state_q == IDLE) && any_req;
  assign cnt_last = (cnt_q == CNT_W'(ALU_LAT - 1));

  // One-hot grant to index and selected operand bundle
  always_comb begin
    gidx = '0;
    sel  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx   = ID_W'(i);
        sel.a  = req_a[i*DATA_W +: DATA_W];
        sel.b  = req_b[i*DATA_W +: DATA_W];
        sel.op = op_code_e'(req_op[i*OP_W +: OP_W]);
      end
    end
    ptr_next = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and combinational accept strobe
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready = grant;
          state_d   = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_last) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!rst) req_ready = '0;
  end

  // Datapath: operand capture, latency counter, response capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op_code <= ADD;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_result  <= '0;
    end else begin
      if (accept) begin
        alu_a       <= sel.a;
        alu_b       <= sel.b;
        alu_op_code <= sel.op;
        id_q        <= gidx;
        ptr_q       <= ptr_next;
      end
      if (state_q == ISSUE) cnt_q <= '0;
      if (state_q == WAIT) begin
        if (cnt_last) begin
          cnt_q      <= '0;
          rsp_result <= alu_result;
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      if ((state_q == RESP) && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one ALU.
REQ-002 SHALL have parameter ALU_LAT, default 1, cycles from operands sampled by the ALU to alu_result valid.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester request pending.
REQ-006 req_ready  output  NUM_REQ  one-hot accept strobe, combinational.
REQ-007 req_a  input  NUM_REQ x 32  operand a per requester.
REQ-008 req_b  input  NUM_REQ x 32  operand b per requester.
REQ-009 req_op  input  NUM_REQ x op_code_e  operation per requester.
REQ-010 alu_a  output  32  registered operand a to the ALU.
REQ-011 alu_b  output  32  registered operand b to the ALU.
REQ-012 alu_op_code  output  op_code_e  registered operation to the ALU.
REQ-013 alu_result  input  32  ALU result.
REQ-014 rsp_valid  output  1  response available.
REQ-015 rsp_ready  input  1  response consumer accepts.
REQ-016 rsp_id  output  $clog2(NUM_REQ)  index of the requester owning the response.
REQ-017 rsp_result  output  32  captured ALU result.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-019 In IDLE with any req_valid set, the block SHALL assert req_ready for exactly one requester chosen round-robin starting at the priority pointer, capture that requester's a/b/op and index, and go to ISSUE.
REQ-020 req_ready SHALL be all-zero in every state other than IDLE, and in IDLE when no req_valid is set.
REQ-021 After granting requester i, the priority pointer SHALL become (i+1) mod NUM_REQ; it SHALL NOT change when nothing is granted.
REQ-022 alu_a, alu_b, alu_op_code SHALL take the captured values on entry to ISSUE and hold them stable through ISSUE and WAIT.
REQ-023 ISSUE SHALL last 1 cycle; WAIT SHALL last exactly ALU_LAT cycles, counted by an internal counter.
REQ-024 On the last WAIT cycle the block SHALL register alu_result into rsp_result and go to RESP.
REQ-025 In RESP rsp_valid SHALL be 1 with rsp_id and rsp_result stable until the cycle rsp_ready is 1; the FSM then returns to IDLE.
REQ-026 Timing for ALU_LAT=1: accept in cycle T, operands on ALU in T+1, WAIT in T+2, rsp_valid from T+3; minimum 4 cycles per operation.
REQ-027 No new request SHALL be accepted while rsp_valid is 1, so at most one operation is in flight.
REQ-028 Results SHALL be 32-bit modulo 2^32; the block SHALL NOT alter alu_result.
REQ-029 req_valid deasserting outside IDLE SHALL have no effect on the in-flight operation.

Reset
REQ-030 With rst=0 at a rising edge the block SHALL enter IDLE, set pointer to 0, WAIT counter to 0, alu_a=0, alu_b=0, alu_op_code=ADD, rsp_valid=0, rsp_id=0, rsp_result=0.
REQ-031 Reset in any state, including mid-WAIT or RESP, SHALL discard the in-flight operation with no response produced.
REQ-032 req_ready SHALL be all-zero while rst=0.

Structure
REQ-033 op_code_e (ADD, SUB, AND, NOT), a sched_state_e enum and default constants for NUM_REQ and ALU_LAT SHALL reside in package defs.
REQ-034 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant).

Verification
REQ-035 Req0 only, ADD a=5 b=7 -> req_ready[0] in T, alu_op_code=ADD in T+1, rsp_valid in T+3, rsp_id=0, rsp_result=12.
REQ-036 After reset all four valid: r0 ADD 1+2, r1 SUB 10-3, r2 AND 0xF0F0&0xFF00, r3 NOT b=0 -> grants 0,1,2,3 in order; results 3, 7, 0xF000, 0xFFFFFFFF.
REQ-037 Wrap: SUB a=0 b=1 -> 0xFFFFFFFF; ADD a=0xFFFFFFFF b=1 -> 0.
REQ-038 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_id, rsp_result stable; req_ready all-zero; release -> IDLE next cycle.
REQ-039 rst=0 during WAIT -> next cycle all outputs at reset values, no rsp_valid; next request from r1 and r0 together grants r0.
REQ-040 r0 and r2 held valid continuously -> grant sequence 0,2,0,2; r1 and r3 never granted.
